// File: rtl/xs3_serial_rx.sv
// Serial Excess-3 receiver: assembles LSB-first nibbles into a DIGITS-wide
// word and hands it, with per-digit invalid-code flags, over valid/ready.
module xs3_serial_rx #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic                bit_ready,
    output logic [4*DIGITS-1:0] code_out,
    output logic [DIGITS-1:0]   code_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_abort
);

    localparam int W  = 4 * DIGITS;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIGITS - 1);

    typedef enum logic {ASSEMBLE, STALL} state_t;

    state_t          state_q, state_d;
    logic [1:0]      bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   dig_cnt_q, dig_cnt_d;
    logic [3:0]      nib_q, nib_d;
    logic [W-1:0]    asm_q, asm_d;
    logic [DIGITS-1:0] aerr_q, aerr_d;
    logic [W-1:0]    code_q, code_d;
    logic [DIGITS-1:0] err_q, err_d;
    logic            ov_q, ov_d;
    logic            abort_q, abort_d;

    logic            accept, drain;
    logic [1:0]      bc;
    logic [DW-1:0]   dc;
    logic [3:0]      full;

    assign accept = bit_valid && (state_q == ASSEMBLE);
    assign drain  = ov_q && out_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        dig_cnt_d = dig_cnt_q;
        nib_d     = nib_q;
        asm_d     = asm_q;
        aerr_d    = aerr_q;
        code_d    = code_q;
        err_d     = err_q;
        ov_d      = ov_q;
        abort_d   = 1'b0;
        bc        = bit_cnt_q;
        dc        = dig_cnt_q;
        full      = {bit_in, nib_q[2:0]};

        if (drain) begin
            ov_d = 1'b0;
        end

        if (state_q == STALL) begin
            // Held word replaces the draining one with no bubble.
            if (drain) begin
                code_d  = asm_q;
                err_d   = aerr_q;
                ov_d    = 1'b1;
                state_d = ASSEMBLE;
            end
        end else if (accept) begin
            if (frame_start) begin
                bc      = 2'd0;
                dc      = '0;
                abort_d = (bit_cnt_q != 2'd0) || (dig_cnt_q != '0);
            end
            nib_d[bc] = bit_in;
            bit_cnt_d = bc + 2'd1;
            dig_cnt_d = dc;
            if (bc == 2'd3) begin
                asm_d[W-4-4*int'(dc) +: 4] = full;
                aerr_d[DIGITS-1-int'(dc)]  = (full < 4'h3) || (full > 4'hC);
                if (dc == LAST) begin
                    dig_cnt_d = '0;
                    if (!ov_q || drain) begin
                        code_d = asm_d;
                        err_d  = aerr_d;
                        ov_d   = 1'b1;
                    end else begin
                        state_d = STALL;
                    end
                end else begin
                    dig_cnt_d = dc + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ASSEMBLE;
            bit_cnt_q <= 2'd0;
            dig_cnt_q <= '0;
            nib_q     <= 4'd0;
            asm_q     <= '0;
            aerr_q    <= '0;
            code_q    <= '0;
            err_q     <= '0;
            ov_q      <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            dig_cnt_q <= dig_cnt_d;
            nib_q     <= nib_d;
            asm_q     <= asm_d;
            aerr_q    <= aerr_d;
            code_q    <= code_d;
            err_q     <= err_d;
            ov_q      <= ov_d;
            abort_q   <= abort_d;
        end
    end

    assign bit_ready   = (state_q == ASSEMBLE);
    assign code_out    = code_q;
    assign code_err    = err_q;
    assign out_valid   = ov_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_xs3_serial_rx.sv
// Directed and randomized bench for xs3_serial_rx with DIGITS=4.
// Received words are captured by a monitor and compared to expectations.
module tb_xs3_serial_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_ready;
    logic [15:0] code_out;
    logic [3:0]  code_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        frame_abort;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int abort_cnt = 0;
    bit rand_mode = 1'b0;
    logic [19:0] rx_q[$];
    logic [19:0] exp_q[$];

    xs3_serial_rx #(.DIGITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .bit_ready   (bit_ready),
        .code_out    (code_out),
        .code_err    (code_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only #1 after posedge, so negedge values are what
    // the next posedge will act on.
    always @(negedge clk) begin
        if (out_valid && out_ready) rx_q.push_back({code_err, code_out});
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_err(input logic [15:0] w);
        logic [3:0] e;
        logic [3:0] n;
        for (int d = 0; d < 4; d++) begin
            n = w[15-4*d -: 4];
            e[3-d] = (n < 4'h3) || (n > 4'hC);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        int n;
        logic rdy;
        if (rand_mode) begin
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        bit_valid = 1'b1;
        bit_in = b;
        frame_start = fs;
        n = 0;
        do begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            rdy = bit_ready;
            step();
            n++;
        end while (!rdy && n < 2000);
        if (!rdy) chk("bit_accept_timeout", 32'(rdy), 32'd1);
        bit_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, output int t0);
        t0 = 0;
        for (int k = 0; k < 16; k++) begin
            send_bit(w[12 - 4*(k/4) + (k%4)], k == 0);
            if (k == 0) t0 = cyc;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bit_ready", 32'(bit_ready), 32'd1);
        chk("rst_code_out", 32'(code_out), 32'd0);
        chk("rst_code_err", 32'(code_err), 32'd0);
        chk("rst_abort", 32'(frame_abort), 32'd0);
        step();
    endtask

    initial begin
        int t0;
        int t1;
        int base;
        int abase;
        logic [15:0] w;
        logic [15:0] rw;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_bit_ready", 32'(bit_ready), 32'd1);
        chk("init_code_out", 32'(code_out), 32'd0);
        chk("init_code_err", 32'(code_err), 32'd0);
        chk("init_abort", 32'(frame_abort), 32'd0);
        step();

        // Basic word, latency of one edge after the 16th bit.
        out_ready = 1'b1;
        send_word(16'h37C5, t0);
        t1 = cyc;
        chk("w1_latency", 32'(t1 - t0), 32'd15);
        @(negedge clk);
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_code", 32'(code_out), 32'h37C5);
        chk("w1_err", 32'(code_err), 32'h0);
        step();
        @(negedge clk);
        chk("w1_valid_drop", 32'(out_valid), 32'd0);
        step();

        // Invalid codes pass through with flags.
        send_word(16'h04FA, t0);
        @(negedge clk);
        chk("w2_code", 32'(code_out), 32'h04FA);
        chk("w2_err", 32'(code_err), 32'hA);
        step();

        // Backpressure: second word stalls then follows without a bubble.
        base = rx_q.size();
        out_ready = 1'b0;
        send_word(16'h3333, t0);
        send_word(16'h4444, t0);
        @(negedge clk);
        chk("bp_bit_ready", 32'(bit_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_code", 32'(code_out), 32'h3333);
        step();
        step();
        @(negedge clk);
        chk("bp_code_stable", 32'(code_out), 32'h3333);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_code", 32'(code_out), 32'h4444);
        chk("bp_ready_back", 32'(bit_ready), 32'd1);
        step();
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_rx_count", 32'(rx_q.size() - base), 32'd2);
        if (rx_q.size() >= base + 2) begin
            chk("bp_rx0", 32'(rx_q[base]), 32'h03333);
            chk("bp_rx1", 32'(rx_q[base+1]), 32'h04444);
        end
        step();

        // Truncated frame is dropped with a single abort pulse.
        base = rx_q.size();
        abase = abort_cnt;
        w = 16'h962B;
        send_bit(1'b1, 1'b1);
        for (int k = 1; k < 6; k++) send_bit(1'(k % 2), 1'b0);
        send_bit(w[12], 1'b1);
        @(negedge clk);
        chk("ab_pulse", 32'(frame_abort), 32'd1);
        step();
        @(negedge clk);
        chk("ab_pulse_end", 32'(frame_abort), 32'd0);
        step();
        for (int k = 1; k < 16; k++) send_bit(w[12 - 4*(k/4) + (k%4)], 1'b0);
        step();
        @(negedge clk);
        chk("ab_rx_count", 32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) chk("ab_rx_word", 32'(rx_q[base]), 32'h2962B);
        chk("ab_count", 32'(abort_cnt - abase), 32'd1);
        step();

        // Reset mid-word with an occupied output register.
        base = rx_q.size();
        out_ready = 1'b0;
        send_word(16'h3456, t0);
        for (int k = 0; k < 5; k++) send_bit(1'b1, k == 0);
        do_reset();
        // Reset while stalled.
        send_word(16'h5555, t0);
        send_word(16'h6666, t0);
        @(negedge clk);
        chk("stall_before_rst", 32'(bit_ready), 32'd0);
        step();
        do_reset();
        out_ready = 1'b1;
        send_word(16'hD3C3, t0);
        step();
        @(negedge clk);
        chk("rst_rx_count", 32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) chk("rst_rx_word", 32'(rx_q[base]), 32'h8D3C3);
        step();

        // Randomized gaps and backpressure over 1000 words.
        base = rx_q.size();
        rand_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            w = 16'($urandom);
            exp_q.push_back({exp_err(w), w});
            send_word(w, t0);
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) step();
        step();
        @(negedge clk);
        chk("rnd_rx_count", 32'(rx_q.size() - base), 32'd1000);
        for (int k = 0; k < 1000 && base + k < rx_q.size(); k++) begin
            chk($sformatf("rnd_word%0d", k), 32'(rx_q[base+k]), 32'(exp_q[k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
